// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch : instruction-fetch producer for the IF/ID pipeline register.
//
// Owns the program counter and runs a req/ready handshake with instruction
// memory. Presents {IF_pc_plus_4, IF_ins} together with id_en, the IF/ID load
// enable. Applies hazard-unit stalls and ID-stage branch/jump redirects and
// sustains one instruction per cycle when imem answers with zero wait states.
//
// Parameters
//   RESET_PC         PC loaded on reset (bits [1:0] must be 0)
//
// Ports
//   clk              in   1   clock, all state updates on posedge
//   rst_n            in   1   asynchronous active-low reset
//   stall            in   1   hazard unit: hold current instruction
//   redirect         in   1   ID stage: branch taken / jump this cycle
//   redirect_target  in   32  new PC on redirect (bits [1:0] forced to 0)
//   imem_req         out  1   fetch request (registered, high only in FETCH)
//   imem_addr        out  32  word-aligned fetch address (= pc)
//   imem_ready       in   1   imem_rdata valid for imem_addr this cycle
//   imem_rdata       in   32  instruction word
//   IF_pc_plus_4     out  32  pc + 4 (registered alongside pc)
//   IF_ins           out  32  instruction toward IF/ID
//   id_en            out  1   IF/ID load enable
//
// Configuration macro
//   IF_FETCH_FLUSH_NOP_EN  when defined, a redirect cycle loads a NOP bubble
//                          into IF/ID (id_en=1, IF_ins=0). When undefined,
//                          id_en=0 in a redirect cycle and squashing is left
//                          to downstream logic.
// -----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_pc_plus_4,
  output logic [31:0] IF_ins,
  output logic        id_en
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

  // Next sequential word address; 32-bit modular so 32'hFFFF_FFFC wraps to 0.
  function automatic logic [31:0] f_next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus_4;
  logic [31:0] r_ins_buf;
  logic        r_imem_req;

  logic [31:0] w_target;
  logic        w_redirect_act;
  logic        w_out_valid;
  logic [31:0] w_ins_raw;
  logic        w_id_en;
  logic [31:0] w_if_ins;

  // Redirect targets are forced word aligned.
  assign w_target = redirect_target & 32'hFFFF_FFFC;

  // The boot cycle ignores redirect; everywhere else it takes effect at once.
  assign w_redirect_act = redirect & (r_state != ST_BOOT);

  // Fetch FSM: pc, pc+4, held instruction and the registered imem request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_pc_plus_4 <= f_next_word(RESET_PC);
      r_ins_buf   <= 32'h0000_0000;
      r_imem_req  <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end

        ST_FETCH: begin
          if (redirect) begin
            // Whatever imem returns this cycle belongs to the wrong path.
            r_pc        <= w_target;
            r_pc_plus_4 <= f_next_word(w_target);
            r_ins_buf   <= 32'h0000_0000;
            r_state     <= ST_FETCH;
            r_imem_req  <= 1'b1;
          end else if (imem_ready && !stall) begin
            // Accepted fetch: move straight on to the next word.
            r_pc        <= r_pc_plus_4;
            r_pc_plus_4 <= f_next_word(r_pc_plus_4);
            r_state     <= ST_FETCH;
            r_imem_req  <= 1'b1;
          end else if (imem_ready && stall) begin
            // Word arrived but IF/ID cannot take it: park it and stop asking.
            r_ins_buf   <= imem_rdata;
            r_state     <= ST_HOLD;
            r_imem_req  <= 1'b0;
          end else begin
            // Wait state: keep the request and address steady.
            r_state     <= ST_FETCH;
            r_imem_req  <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (redirect) begin
            // Parked instruction is on the wrong path; discard it.
            r_pc        <= w_target;
            r_pc_plus_4 <= f_next_word(w_target);
            r_ins_buf   <= 32'h0000_0000;
            r_state     <= ST_FETCH;
            r_imem_req  <= 1'b1;
          end else if (!stall) begin
            // Parked word is loaded into IF/ID this cycle.
            r_pc        <= r_pc_plus_4;
            r_pc_plus_4 <= f_next_word(r_pc_plus_4);
            r_state     <= ST_FETCH;
            r_imem_req  <= 1'b1;
          end else begin
            r_state     <= ST_HOLD;
            r_imem_req  <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: recover through the boot path.
          r_state     <= ST_BOOT;
          r_pc        <= RESET_PC;
          r_pc_plus_4 <= f_next_word(RESET_PC);
          r_ins_buf   <= 32'h0000_0000;
          r_imem_req  <= 1'b0;
        end
      endcase
    end
  end

  // Source and validity of the instruction offered to IF/ID in each state.
  always_comb begin
    w_out_valid = 1'b0;
    w_ins_raw   = 32'h0000_0000;
    case (r_state)
      ST_FETCH: begin
        w_out_valid = imem_ready;
        w_ins_raw   = imem_rdata;
      end
      ST_HOLD: begin
        w_out_valid = 1'b1;
        w_ins_raw   = r_ins_buf;
      end
      default: begin
        w_out_valid = 1'b0;
        w_ins_raw   = 32'h0000_0000;
      end
    endcase
  end

  // IF/ID load enable and instruction, including redirect-cycle handling.
  always_comb begin
    w_id_en  = 1'b0;
    w_if_ins = w_ins_raw;
`ifdef IF_FETCH_FLUSH_NOP_EN
    if (w_redirect_act) begin
      // Load a bubble so the wrong-path slot in IF/ID becomes a NOP.
      w_id_en  = 1'b1;
      w_if_ins = 32'h0000_0000;
    end else begin
      w_id_en  = w_out_valid & ~stall;
      w_if_ins = w_ins_raw;
    end
`else
    if (w_redirect_act) begin
      // IF/ID keeps its previous contents; downstream squashes it.
      w_id_en  = 1'b0;
      w_if_ins = w_ins_raw;
    end else begin
      w_id_en  = w_out_valid & ~stall;
      w_if_ins = w_ins_raw;
    end
`endif
  end

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_pc;
  assign IF_pc_plus_4 = r_pc_plus_4;
  assign IF_ins       = w_if_ins;
  assign id_en        = w_id_en;

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch : self-checking bench for if_fetch.
//
// A behavioural model (pc, a "booting" flag and an optional parked word)
// predicts every output on every falling edge; directed literal checks pin the
// model at hand-computed points. A second instance with RESET_PC=32'hFFFF_FFFC
// covers the address wrap.
// -----------------------------------------------------------------------------
module tb_if_fetch;

  localparam logic [31:0] RP   = 32'h0000_0000;
  localparam logic [31:0] RP_W = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0000_0000;
  logic        imem_ready = 1'b1;
  logic [31:0] tb_mask = 32'h0000_0000;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_pc_plus_4;
  logic [31:0] IF_ins;
  logic        id_en;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_p4;
  logic [31:0] w_ins;
  logic        w_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // imem returns its own address, optionally scrambled by tb_mask.
  assign imem_rdata = imem_addr ^ tb_mask;

  if_fetch #(.RESET_PC(RP)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .IF_pc_plus_4(IF_pc_plus_4),
    .IF_ins(IF_ins), .id_en(id_en)
  );

  if_fetch #(.RESET_PC(RP_W)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect(1'b0),
    .redirect_target(32'h0000_0000), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(w_addr), .IF_pc_plus_4(w_p4),
    .IF_ins(w_ins), .id_en(w_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_boot = 1'b1;
  logic [31:0] m_pc = RP;
  logic        m_held_v = 1'b0;
  logic [31:0] m_held_w = 32'h0000_0000;

  // Model state advance: what the fetch unit must remember after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot   <= 1'b1;
      m_pc     <= RP;
      m_held_v <= 1'b0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (redirect) begin
      m_pc     <= redirect_target & 32'hFFFF_FFFC;
      m_held_v <= 1'b0;
    end else if (m_held_v) begin
      if (!stall) begin
        m_pc     <= m_pc + 32'd4;
        m_held_v <= 1'b0;
      end
    end else if (imem_ready) begin
      if (stall) begin
        m_held_v <= 1'b1;
        m_held_w <= imem_rdata;
      end else begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  logic        e_req, e_valid, e_id, e_red;
  logic [31:0] e_addr, e_p4, e_ins;

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      e_req = 1'b0; e_addr = RP; e_p4 = RP + 32'd4; e_id = 1'b0; e_ins = 32'h0000_0000;
    end else begin
      e_addr = m_pc;
      e_p4   = m_pc + 32'd4;
      if (m_boot) begin
        e_req = 1'b0; e_valid = 1'b0; e_ins = 32'h0000_0000;
      end else if (m_held_v) begin
        e_req = 1'b0; e_valid = 1'b1; e_ins = m_held_w;
      end else begin
        e_req = 1'b1; e_valid = imem_ready; e_ins = imem_rdata;
      end
      e_red = redirect & ~m_boot;
`ifdef IF_FETCH_FLUSH_NOP_EN
      if (e_red) begin
        e_id = 1'b1; e_ins = 32'h0000_0000;
      end else begin
        e_id = e_valid & ~stall;
      end
`else
      e_id = e_valid & ~stall & ~e_red;
`endif
    end
    check("model_imem_req", {31'd0, imem_req}, {31'd0, e_req});
    check("model_imem_addr", imem_addr, e_addr);
    check("model_pc_plus_4", IF_pc_plus_4, e_p4);
    check("model_id_en", {31'd0, id_en}, {31'd0, e_id});
    if (e_id || !rst_n) check("model_IF_ins", IF_ins, e_ins);
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    @(negedge clk);                                   // t=10, in reset
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0000);
    check("rst_p4", IF_pc_plus_4, 32'h0000_0004);
    check("rst_ins", IF_ins, 32'h0000_0000);
    check("rst_id_en", {31'd0, id_en}, 32'd0);
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
    check("wrap_rst_p4", w_p4, 32'h0000_0000);

    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);                                   // BOOT
    check("boot_req", {31'd0, imem_req}, 32'd0);
    check("boot_id_en", {31'd0, id_en}, 32'd0);
    @(negedge clk);                                   // first fetch, pc=0
    check("t1_ins0", IF_ins, 32'h0000_0000);
    check("t1_p4_0", IF_pc_plus_4, 32'h0000_0004);
    check("t1_id_en0", {31'd0, id_en}, 32'd1);
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("wrap_fetch_p4", w_p4, 32'h0000_0000);
    check("wrap_fetch_id", {31'd0, w_id}, 32'd1);
    @(negedge clk);                                   // pc=4
    check("t1_ins4", IF_ins, 32'h0000_0004);
    check("t1_p4_8", IF_pc_plus_4, 32'h0000_0008);
    check("wrap_next_addr", w_addr, 32'h0000_0000);
    check("wrap_next_p4", w_p4, 32'h0000_0004);

    // Three wait states at pc=8.
    @(posedge clk); #1 imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_wait_addr", imem_addr, 32'h0000_0008);
      check("t2_wait_id_en", {31'd0, id_en}, 32'd0);
      check("t2_wait_req", {31'd0, imem_req}, 32'd1);
    end
    @(posedge clk); #1 imem_ready = 1'b1;
    @(negedge clk);
    check("t2_ins8", IF_ins, 32'h0000_0008);
    check("t2_id_en", {31'd0, id_en}, 32'd1);

    // Stall two cycles at pc=12 while imem is ready.
    @(posedge clk); #1 stall = 1'b1;
    @(negedge clk);
    check("t3_addr12", imem_addr, 32'h0000_000C);
    check("t3_id_en_fetch", {31'd0, id_en}, 32'd0);
    @(posedge clk); #1 tb_mask = 32'hDEAD_0000;
    @(negedge clk);
    check("t3_hold_req", {31'd0, imem_req}, 32'd0);
    check("t3_hold_id_en", {31'd0, id_en}, 32'd0);
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    check("t3_release_id_en", {31'd0, id_en}, 32'd1);
    check("t3_release_ins", IF_ins, 32'h0000_000C);
    @(posedge clk); #1 tb_mask = 32'h0000_0000; stall = 1'b1;
    @(negedge clk);
    check("t3_next_addr", imem_addr, 32'h0000_0010);
    check("t3_next_req", {31'd0, imem_req}, 32'd1);

    // Now in HOLD with word 16 parked; redirect with stall still high.
    @(posedge clk); #1 redirect = 1'b1; redirect_target = 32'h0000_0103;
    @(negedge clk);
`ifdef IF_FETCH_FLUSH_NOP_EN
    check("t4_redirect_id_en", {31'd0, id_en}, 32'd1);
    check("t4_redirect_nop", IF_ins, 32'h0000_0000);
`else
    check("t4_redirect_id_en", {31'd0, id_en}, 32'd0);
`endif
    @(posedge clk); #1 redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("t4_target_addr", imem_addr, 32'h0000_0100);
    check("t4_target_ins", IF_ins, 32'h0000_0100);
    check("t4_target_id_en", {31'd0, id_en}, 32'd1);

    // Redirect during a wait state.
    @(posedge clk); #1 imem_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_0200;
    @(negedge clk);
`ifdef IF_FETCH_FLUSH_NOP_EN
    check("t4b_id_en", {31'd0, id_en}, 32'd1);
`else
    check("t4b_id_en", {31'd0, id_en}, 32'd0);
`endif
    @(posedge clk); #1 redirect = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    check("t4b_addr", imem_addr, 32'h0000_0200);

    // Asynchronous reset in the middle of a wait state at pc=0x204.
    @(posedge clk); #1 imem_ready = 1'b0;
    @(negedge clk);
    check("t6_wait_addr", imem_addr, 32'h0000_0204);
    check("t6_wait_req", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_req", {31'd0, imem_req}, 32'd0);
    check("t6_async_addr", imem_addr, 32'h0000_0000);
    check("t6_async_p4", IF_pc_plus_4, 32'h0000_0004);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1; imem_ready = 1'b1;
    @(negedge clk);
    check("t6_boot_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("t6_refetch_req", {31'd0, imem_req}, 32'd1);
    check("t6_refetch_addr", imem_addr, 32'h0000_0000);
    check("t6_refetch_id_en", {31'd0, id_en}, 32'd1);

    // Mixed directed pattern; the model checks every cycle.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      stall           = ((i % 5) == 2) || ((i % 7) == 3);
      redirect        = ((i % 11) == 6);
      imem_ready      = ((i % 4) != 1);
      redirect_target = 32'h0000_1000 + 32'(i) * 32'd16 + 32'd3;
      tb_mask         = 32'(i) * 32'h0101_0000;
    end
    @(posedge clk); #1;
    stall = 1'b0; redirect = 1'b0; imem_ready = 1'b1; tb_mask = 32'h0000_0000;
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
